// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding and parity-type constants,
// used by both the TX parity generator and the RX parity checker.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Width of a counter that must reach n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Parity bit the transmitter sends for a word whose bits XOR to data_xor.
  function automatic logic expected_parity(input logic par_typ, input logic data_xor);
    return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/parity_check_if.sv
// Bit-sampler side and RX-FSM side signals of the RX parity checker.
// With `PAR_ERR_CNT_EN defined, the error-counter clear and count are added.
interface parity_check_if #(
  parameter int DATA_WIDTH    = 8
`ifdef PAR_ERR_CNT_EN
  , parameter int ERR_CNT_WIDTH = 8
`endif
);
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  start;
  logic                  bit_valid;
  logic                  sampled_bit;
  logic                  busy;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
`ifdef PAR_ERR_CNT_EN
  logic                     err_cnt_clr;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
`endif

  modport master (
    output PAR_EN, PAR_TYP, start, bit_valid, sampled_bit,
`ifdef PAR_ERR_CNT_EN
    output err_cnt_clr,
    input  err_cnt,
`endif
    input  busy, P_DATA, data_valid, par_err
  );

  modport slave (
    input  PAR_EN, PAR_TYP, start, bit_valid, sampled_bit,
`ifdef PAR_ERR_CNT_EN
    input  err_cnt_clr,
    output err_cnt,
`endif
    output busy, P_DATA, data_valid, par_err
  );

endinterface

// File: rtl/rx_bit_counter.sv
// Data-bit counter for one RX frame: counts accepted bits, flags the last
// one (count == DATA_WIDTH-1). Synchronous clear has priority over enable.
module rx_bit_counter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);
  localparam int CNT_W = cnt_width(DATA_WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear first, then increment on an accepted bit.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/parity_check.sv
// RX parity checker: deserialises DATA_WIDTH bits (LSB first) plus an optional
// parity bit, recomputes parity and flags a mismatch. Define `PAR_ERR_CNT_EN to
// add a saturating parity-error counter with a clear input.
module parity_check
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = 8
`ifdef PAR_ERR_CNT_EN
  , parameter int ERR_CNT_WIDTH = 8
`endif
) (
  input logic          CLK,
  input logic          RST,
  parity_check_if.slave bus
);
  uart_state_e           state_q, state_d;
  logic                  par_en_q, par_typ_q, xor_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q;
  logic                  data_valid_q, par_err_q, busy_q;
  logic                  bit_accept, cnt_en, cnt_clr, cnt_tc;
  logic                  last_bit, parity_bit, parity_bad;

  // start wins over a coincident bit strobe; that bit is dropped.
  assign bit_accept = bus.bit_valid & ~bus.start;
  assign cnt_en     = bit_accept & (state_q == DATA);
  assign last_bit   = cnt_en & cnt_tc;
  assign parity_bit = bit_accept & (state_q == PARITY);
  assign cnt_clr    = bus.start | last_bit;
  assign shift_d    = {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
  assign parity_bad = (bus.sampled_bit != expected_parity(par_typ_q, xor_q));

  rx_bit_counter #(.DATA_WIDTH(DATA_WIDTH)) u_bit_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (cnt_en),
    .clr_i (cnt_clr),
    .tc_o  (cnt_tc)
  );

  // Next-state: start restarts from any state; DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = DATA;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        DATA:    if (last_bit) state_d = par_en_q ? PARITY : DONE;
        PARITY:  if (parity_bit) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame datapath: config latch, shift/XOR accumulation, registered outputs.
  // NOTE: the shift register is small control-path state, so it is reset like the rest.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      xor_q        <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      busy_q       <= (state_d == DATA) || (state_d == PARITY);
      if (bus.start) begin
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
        xor_q     <= 1'b0;
        shift_q   <= '0;
        par_err_q <= 1'b0;
      end else begin
        if (cnt_en) begin
          shift_q <= shift_d;
          xor_q   <= xor_q ^ bus.sampled_bit;
        end
        if (last_bit && !par_en_q) begin
          p_data_q     <= shift_d;
          data_valid_q <= 1'b1;
        end
        if (parity_bit) begin
          p_data_q     <= shift_q;
          data_valid_q <= 1'b1;
          par_err_q    <= parity_bad;
        end
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.P_DATA     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;

`ifdef PAR_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  // Saturating count of frames completing with a parity error; clear wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                      err_cnt_q <= '0;
    else if (bus.err_cnt_clr)                     err_cnt_q <= '0;
    else if (parity_bit && parity_bad && (err_cnt_q != '1))
                                                  err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_check.sv
// Bench for parity_check (DATA_WIDTH=8): table of frames plus hand-written
// abort / reset / start-collision sequences; completed words are checked
// against a scoreboard queue. With `PAR_ERR_CNT_EN, ERR_CNT_WIDTH=2.
module tb_parity_check;
  import uart_pkg::*;

  localparam int DW = 8;
`ifdef PAR_ERR_CNT_EN
  localparam int ECW = 2;
`endif

  typedef struct {
    logic       par_en;
    logic       par_typ;
    logic [7:0] data;
    logic       pbit;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  parity_check_if #(
    .DATA_WIDTH(DW)
`ifdef PAR_ERR_CNT_EN
    , .ERR_CNT_WIDTH(ECW)
`endif
  ) bus ();

  parity_check #(
    .DATA_WIDTH(DW)
`ifdef PAR_ERR_CNT_EN
    , .ERR_CNT_WIDTH(ECW)
`endif
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int   errors   = 0;
  int   checks   = 0;
  int   dv_count = 0;
  int   target   = 0;
  exp_t sb_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every data_valid pulse must match the oldest pending frame.
  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b0 && bus.data_valid === 1'b1) begin
      dv_count++;
      check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("p_data", 32'(bus.P_DATA), 32'(e.data));
        check("par_err", 32'(bus.par_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.bit_valid   = 1'b1;
    bus.sampled_bit = b;
    tick();
    bus.bit_valid   = 1'b0;
  endtask

  task automatic set_clr(input logic v);
`ifdef PAR_ERR_CNT_EN
    bus.err_cnt_clr = v;
`else
    if (v) $display("note: error-counter clear requested without counter");
`endif
  endtask

  // Full frame; PAR_EN/PAR_TYP are inverted after start to show they are latched.
  task automatic send_frame(input logic en, input logic typ, input logic [7:0] data,
                            input logic pbit, input logic clr_last);
    bus.PAR_EN  = en;
    bus.PAR_TYP = typ;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.PAR_EN  = ~en;
    bus.PAR_TYP = ~typ;
    for (int i = 0; i < DW; i++) begin
      if (!en && i == DW - 1) set_clr(clr_last);
      send_bit(data[i]);
    end
    if (en) begin
      set_clr(clr_last);
      send_bit(pbit);
    end
    set_clr(1'b0);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    sb_q.push_back(x);
    target++;
  endtask

  // Bounded wait for the data_valid count to reach target.
  task automatic wait_dv(input string name);
    for (int k = 0; k < 8 && dv_count < target; k++) begin
      @(negedge CLK);
      #1;
    end
    check(name, 32'(dv_count), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, PAR_EVEN, 8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, PAR_ODD,  8'hA5, 1'b0, 8'hA5, 1'b1};
    vecs[2] = '{1'b0, PAR_EVEN, 8'h3C, 1'b0, 8'h3C, 1'b0};
    vecs[3] = '{1'b1, PAR_EVEN, 8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{1'b1, PAR_ODD,  8'h00, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{1'b1, PAR_EVEN, 8'h01, 1'b0, 8'h01, 1'b1};
    vecs[6] = '{1'b1, PAR_ODD,  8'h7E, 1'b1, 8'h7E, 1'b0};
    vecs[7] = '{1'b0, PAR_ODD,  8'h81, 1'b1, 8'h81, 1'b0};

    bus.PAR_EN      = 1'b0;
    bus.PAR_TYP     = 1'b0;
    bus.start       = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.sampled_bit = 1'b0;
`ifdef PAR_ERR_CNT_EN
    bus.err_cnt_clr = 1'b0;
`endif
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_p_data", 32'(bus.P_DATA), 32'd0);
    check("rst_data_valid", 32'(bus.data_valid), 32'd0);
    check("rst_par_err", 32'(bus.par_err), 32'd0);
`ifdef PAR_ERR_CNT_EN
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif
    @(posedge CLK);
    #1 RST = 1'b0;
    tick();

    // Table of complete frames.
    for (int i = 0; i < 8; i++) begin
      expect_frame(vecs[i].exp_data, vecs[i].exp_err);
      send_frame(vecs[i].par_en, vecs[i].par_typ, vecs[i].data, vecs[i].pbit, 1'b0);
      wait_dv("dv_table");
      check("busy_after_done", 32'(bus.busy), 32'd0);
    end

    // par_err holds until the next start, then clears; busy rises with the frame.
    expect_frame(8'hA5, 1'b1);
    send_frame(1'b1, PAR_ODD, 8'hA5, 1'b0, 1'b0);
    wait_dv("dv_odd_err");
    repeat (5) tick();
    check("par_err_hold", 32'(bus.par_err), 32'd1);
    bus.PAR_EN  = 1'b1;
    bus.PAR_TYP = PAR_EVEN;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    check("par_err_clr_on_start", 32'(bus.par_err), 32'd0);
    check("busy_in_frame", 32'(bus.busy), 32'd1);

    // Abort after 4 bits by a new start: only the second frame completes.
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    expect_frame(8'hFF, 1'b0);
    send_frame(1'b1, PAR_EVEN, 8'hFF, 1'b0, 1'b0);
    wait_dv("dv_after_abort");
    repeat (4) tick();
    check("abort_single_dv", 32'(dv_count), 32'(target));

    // No parity: a 9th strobe after completion is ignored.
    expect_frame(8'h3C, 1'b0);
    send_frame(1'b0, PAR_EVEN, 8'h3C, 1'b0, 1'b0);
    wait_dv("dv_no_parity");
    send_bit(1'b1);
    repeat (3) tick();
    check("ninth_bit_ignored", 32'(dv_count), 32'(target));
    check("ninth_bit_busy", 32'(bus.busy), 32'd0);
    check("ninth_bit_par_err", 32'(bus.par_err), 32'd0);

    // start and bit_valid together: the coincident bit is dropped.
    expect_frame(8'h00, 1'b0);
    bus.PAR_EN      = 1'b0;
    bus.start       = 1'b1;
    bus.bit_valid   = 1'b1;
    bus.sampled_bit = 1'b1;
    tick();
    bus.start       = 1'b0;
    bus.bit_valid   = 1'b0;
    for (int i = 0; i < DW; i++) send_bit(1'b0);
    wait_dv("dv_start_collision");

    // Reset mid-frame clears every output; strobes without start do nothing.
    expect_frame(8'hA5, 1'b1);
    send_frame(1'b1, PAR_ODD, 8'hA5, 1'b0, 1'b0);
    wait_dv("dv_before_reset");
    bus.PAR_EN = 1'b1;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    RST = 1'b1;
    #2;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_p_data", 32'(bus.P_DATA), 32'd0);
    check("midrst_data_valid", 32'(bus.data_valid), 32'd0);
    check("midrst_par_err", 32'(bus.par_err), 32'd0);
`ifdef PAR_ERR_CNT_EN
    check("midrst_err_cnt", 32'(bus.err_cnt), 32'd0);
`endif
    @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    repeat (3) tick();
    check("no_start_no_dv", 32'(dv_count), 32'(target));
    check("no_start_busy", 32'(bus.busy), 32'd0);
    expect_frame(8'hA5, 1'b0);
    send_frame(1'b1, PAR_EVEN, 8'hA5, 1'b0, 1'b0);
    wait_dv("dv_after_reset");

`ifdef PAR_ERR_CNT_EN
    // Saturating error counter (2 bits) and clear-over-increment priority.
    for (int i = 1; i <= 4; i++) begin
      expect_frame(8'h00, 1'b1);
      send_frame(1'b1, PAR_ODD, 8'h00, 1'b0, 1'b0);
      wait_dv("dv_cnt");
      check("err_cnt_sat", 32'(bus.err_cnt), (i < 3) ? 32'(i) : 32'd3);
    end
    expect_frame(8'h00, 1'b1);
    send_frame(1'b1, PAR_ODD, 8'h00, 1'b0, 1'b1);
    wait_dv("dv_cnt_clr");
    check("err_cnt_clr_wins", 32'(bus.err_cnt), 32'd0);
    expect_frame(8'h00, 1'b1);
    send_frame(1'b1, PAR_ODD, 8'h00, 1'b0, 1'b0);
    wait_dv("dv_cnt_after_clr");
    check("err_cnt_after_clr", 32'(bus.err_cnt), 32'd1);
    expect_frame(8'hA5, 1'b0);
    send_frame(1'b1, PAR_EVEN, 8'hA5, 1'b0, 1'b0);
    wait_dv("dv_cnt_good");
    check("err_cnt_good_frame", 32'(bus.err_cnt), 32'd1);
`endif

    repeat (2) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
